// File: rtl/gradient_channel_scheduler_if.sv
// Pixel-in / result-out handshake bundle for gradient_channel_scheduler.
// master: the pixel producer plus the result consumer (pipeline / bench side).
// slave:  the scheduler itself.
interface gradient_channel_scheduler_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [8:0] gradientX_R;
  logic signed [8:0] gradientX_G;
  logic signed [8:0] gradientX_B;
  logic signed [8:0] gradientY_R;
  logic signed [8:0] gradientY_G;
  logic signed [8:0] gradientY_B;
  logic              out_valid;
  logic              out_ready;
  logic [16:0]       modulusSquared;
  logic signed [8:0] gradientX;
  logic signed [8:0] gradientY;
  logic [1:0]        channel;

  modport master (
    output in_valid, gradientX_R, gradientX_G, gradientX_B,
           gradientY_R, gradientY_G, gradientY_B, out_ready,
    input  in_ready, out_valid, modulusSquared, gradientX, gradientY, channel
  );

  modport slave (
    input  in_valid, gradientX_R, gradientX_G, gradientX_B,
           gradientY_R, gradientY_G, gradientY_B, out_ready,
    output in_ready, out_valid, modulusSquared, gradientX, gradientY, channel
  );
endinterface

// File: rtl/gradient_channel_scheduler.sv
// Sequential max-gradient channel select. One shared squarer-adder evaluates
// gx^2+gy^2 for R, G and B on consecutive cycles. A running maximum picks the
// winner, with R > G > B priority on ties. The winner is presented on a
// valid/ready output.
module gradient_channel_scheduler (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sync_clr,
  gradient_channel_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CH_R, CH_G, CH_B, HOLD} state_t;

  state_t state, state_nxt;

  // Captured pixel.
  logic signed [8:0] gx_r_q, gx_g_q, gx_b_q;
  logic signed [8:0] gy_r_q, gy_g_q, gy_b_q;

  // Running maximum (full 18-bit sum so comparisons see past saturation).
  logic [17:0]       max_sum_q;
  logic signed [8:0] max_gx_q, max_gy_q;
  logic [1:0]        max_ch_q;

  // Registered result.
  logic [16:0]       res_mod_q;
  logic signed [8:0] res_gx_q, res_gy_q;
  logic [1:0]        res_ch_q;

  // Shared squarer-adder operands and result.
  logic signed [8:0]  op_gx, op_gy;
  logic signed [17:0] op_gx_ext, op_gy_ext;
  logic signed [17:0] sq_x, sq_y;
  logic [17:0]        sum;
  logic               better;
  logic               accept;

  assign bus.in_ready  = (state == IDLE) | ((state == HOLD) & bus.out_ready);
  assign bus.out_valid = (state == HOLD);
  assign accept        = bus.in_valid & bus.in_ready & ~sync_clr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. sync_clr overrides every transition.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = CH_R;
      CH_R:    state_nxt = CH_G;
      CH_G:    state_nxt = CH_B;
      CH_B:    state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = bus.in_valid ? CH_R : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (sync_clr) state_nxt = IDLE;
  end

  // Operand mux: select the channel the squarer works on this cycle.
  always_comb begin
    op_gx = gx_r_q;
    op_gy = gy_r_q;
    unique case (state)
      CH_G: begin
        op_gx = gx_g_q;
        op_gy = gy_g_q;
      end
      CH_B: begin
        op_gx = gx_b_q;
        op_gy = gy_b_q;
      end
      default: begin
        op_gx = gx_r_q;
        op_gy = gy_r_q;
      end
    endcase
  end

  // Single squarer-adder. Each square fits 17 bits (max 65536) and the sum
  // fits 18 bits (max 131072).
  assign op_gx_ext = 18'(op_gx);
  assign op_gy_ext = 18'(op_gy);
  assign sq_x      = op_gx_ext * op_gx_ext;
  assign sq_y      = op_gy_ext * op_gy_ext;
  assign sum       = $unsigned(sq_x) + $unsigned(sq_y);
  // Strict greater-than keeps the earlier channel on ties (R > G > B).
  assign better    = sum > max_sum_q;

  // Input capture on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this small register bank is reset (not left as uninitialised
    // storage) so the design leaves reset in a fully known state.
    if (!rst_n) begin
      gx_r_q <= '0; gx_g_q <= '0; gx_b_q <= '0;
      gy_r_q <= '0; gy_g_q <= '0; gy_b_q <= '0;
    end else if (sync_clr) begin
      gx_r_q <= '0; gx_g_q <= '0; gx_b_q <= '0;
      gy_r_q <= '0; gy_g_q <= '0; gy_b_q <= '0;
    end else if (accept) begin
      gx_r_q <= bus.gradientX_R;
      gx_g_q <= bus.gradientX_G;
      gx_b_q <= bus.gradientX_B;
      gy_r_q <= bus.gradientY_R;
      gy_g_q <= bus.gradientY_G;
      gy_b_q <= bus.gradientY_B;
    end
  end

  // Running-max tracking and result load at the end of the B step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_sum_q <= '0; max_gx_q <= '0; max_gy_q <= '0; max_ch_q <= '0;
      res_mod_q <= '0; res_gx_q <= '0; res_gy_q <= '0; res_ch_q <= '0;
    end else if (sync_clr) begin
      max_sum_q <= '0; max_gx_q <= '0; max_gy_q <= '0; max_ch_q <= '0;
      res_mod_q <= '0; res_gx_q <= '0; res_gy_q <= '0; res_ch_q <= '0;
    end else begin
      unique case (state)
        CH_R: begin
          max_sum_q <= sum;
          max_gx_q  <= op_gx;
          max_gy_q  <= op_gy;
          max_ch_q  <= 2'd0;
        end
        CH_G: begin
          if (better) begin
            max_sum_q <= sum;
            max_gx_q  <= op_gx;
            max_gy_q  <= op_gy;
            max_ch_q  <= 2'd1;
          end
        end
        CH_B: begin
          if (better) begin
            max_sum_q <= sum;
            max_gx_q  <= op_gx;
            max_gy_q  <= op_gy;
            max_ch_q  <= 2'd2;
            res_mod_q <= sum[17] ? 17'h1FFFF : sum[16:0];
            res_gx_q  <= op_gx;
            res_gy_q  <= op_gy;
            res_ch_q  <= 2'd2;
          end else begin
            res_mod_q <= max_sum_q[17] ? 17'h1FFFF : max_sum_q[16:0];
            res_gx_q  <= max_gx_q;
            res_gy_q  <= max_gy_q;
            res_ch_q  <= max_ch_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs read as zero whenever no result is presented.
  assign bus.modulusSquared = bus.out_valid ? res_mod_q : '0;
  assign bus.gradientX      = bus.out_valid ? res_gx_q  : '0;
  assign bus.gradientY      = bus.out_valid ? res_gy_q  : '0;
  assign bus.channel        = bus.out_valid ? res_ch_q  : '0;

endmodule
